axi_lite_timer: RTL and testbench
=================================

Name: axi_lite_timer

Overview:
- AXI4-Lite slave timer/compare peripheral that sits downstream of axi_lite_interconnect as an additional slave port, beside dmem_axi_lite and imem_axi_lite.
- Provides a prescaled 32-bit up-counter, a compare register, a sticky match flag and a level interrupt output.
- Lets PicoRV32 firmware do timeouts and periodic ticks without polling the cycle CSRs.

Parameters:
- ADDR_WIDTH, 32, AXI address width; only addr[4:2] are decoded.
- DATA_WIDTH, 32, AXI data width; only 32 is supported.
- PRESCALE_WIDTH, 16, width of the PRESCALE register and the prescale counter.
- RESET_COMPARE, 32'hFFFF_FFFF, reset value of COMPARE.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- i_axi_awvalid  input  1  write address valid.
- o_axi_awready  output  1  write address ready.
- i_axi_awaddr  input  ADDR_WIDTH  write address.
- i_axi_wvalid  input  1  write data valid.
- o_axi_wready  output  1  write data ready.
- i_axi_wdata  input  DATA_WIDTH  write data.
- i_axi_wstrb  input  4  byte enables.
- o_axi_bvalid  output  1  write response valid; response is always OKAY, so there is no bresp port.
- i_axi_bready  input  1  write response ready.
- i_axi_arvalid  input  1  read address valid.
- o_axi_arready  output  1  read address ready.
- i_axi_araddr  input  ADDR_WIDTH  read address.
- o_axi_rvalid  output  1  read data valid.
- i_axi_rready  input  1  read data ready.
- o_axi_rdata  output  DATA_WIDTH  read data.
- o_irq  output  1  level interrupt, equal to STATUS.match AND CTRL.irq_en.

Behaviour:
Clock and reset (already decided): one clock, clk; reset is synchronous and active-high, sampled on the rising edge of clk.

Register map (byte offsets, decoded from addr[4:2]):
- 0x00 CTRL: bit0 enable, bit1 irq_en, bit2 auto_reload; other bits read 0.
- 0x04 PRESCALE: RW, [PRESCALE_WIDTH-1:0].
- 0x08 COUNT: RW.
- 0x0C COMPARE: RW.
- 0x10 STATUS: bit0 match; write 1 to clear; reads 0 elsewhere.
- 0x14–0x1C: unmapped. Writes are ignored but still get bvalid; reads return 0 with rvalid.

Reset values:
- All outputs 0: awready, wready, bvalid, arready, rvalid, rdata, irq.
- CTRL=0, PRESCALE=0, COUNT=0, COMPARE=RESET_COMPARE, STATUS=0, prescale counter=0.
- Reset asserted mid-transaction drops bvalid/rvalid in the same edge; the pending transaction is discarded.

Write channel:
- Accept only when awvalid AND wvalid AND NOT bvalid.
- In that cycle, pulse awready and wready high together for exactly one cycle and perform the register write.
- bvalid rises on the next edge and holds until bready is sampled high.
- No new write is accepted while bvalid is high. An AW or W alone is never accepted.
- wstrb applies per byte to CTRL, PRESCALE, COUNT and COMPARE.
- For STATUS, the clear happens only when wstrb[0]=1 and wdata[0]=1.

Read channel:
- Accept when arvalid AND NOT rvalid: pulse arready for one cycle and latch rdata from the register at that time.
- rvalid rises on the next edge (read latency 1) and holds, with rdata stable, until rready is sampled high.
- Read and write channels are independent and may complete in the same cycle.

Counting:
- tick = enable AND (prescale counter == PRESCALE).
- On a tick, the prescale counter goes to 0; otherwise it increments while enabled.
- PRESCALE=0 gives a tick every enabled cycle.
- When enable=0, the prescale counter holds and no ticks occur.
- On a tick, if COUNT == COMPARE:
  - STATUS.match is set.
  - COUNT goes to 0 if auto_reload=1, else COUNT+1.
- On a tick otherwise: COUNT goes to COUNT+1, wrapping from 0xFFFF_FFFF to 0.

Simultaneous events:
- A bus write to COUNT in a cycle with a tick: the bus write wins and the increment is lost.
- A STATUS clear in a cycle where a match sets the flag: the set wins and match stays 1.
- A bus write to PRESCALE resets the prescale counter to 0.

Interrupt:
- o_irq is registered: it follows match AND irq_en one cycle after either changes.

Test Plan:
- Reset, then read all six offsets → rdata 0, 0, 0, 0xFFFF_FFFF, 0, 0; rvalid held until rready. Stall rready 3 cycles → rdata stays stable.
- Write PRESCALE=3, COMPARE=5, CTRL=0x3 → COUNT increments every 4 cycles; match sets when COUNT==5; irq rises 1 cycle later; COUNT continues to 6.
- auto_reload: CTRL=0x5, PRESCALE=0, COMPARE=2 → COUNT sequence 0,1,2,0,1,2; match set on the first wrap. Write STATUS=1 → match clears. irq stays 0 throughout because irq_en=0.
- Write COUNT=0xFFFF_FFFF with enable=1, PRESCALE=0, COMPARE=0x10 → next COUNT is 0, with no match. A COUNT write with wstrb=0x1 of 0xAA onto 0x12345678 → 0x123456AA.
- Hold awvalid high without wvalid for 5 cycles → no awready. Assert wvalid → single awready+wready pulse. Hold bready low 4 cycles → bvalid held high; a second write is not accepted until bready.
- Assert reset while rvalid=1 and COUNT is running → next cycle rvalid=0, COUNT=0, CTRL=0, irq=0.

Source files
------------

// File: rtl/axi_lite_timer.sv
// axi_lite_timer: AXI4-Lite slave timer/compare peripheral.
//
// Prescaled 32-bit up-counter with a compare register, a sticky match flag
// and a registered level interrupt.
//
// Register map (byte offset, decoded from addr[4:2]):
//   0x00 CTRL      bit0 enable, bit1 irq_en, bit2 auto_reload
//   0x04 PRESCALE  [PRESCALE_WIDTH-1:0]
//   0x08 COUNT
//   0x0C COMPARE
//   0x10 STATUS    bit0 match, write 1 to clear
//   0x14-0x1C      unmapped: writes ignored, reads return 0
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   i_axi_aw*/o_axi_aw*   write address channel
//   i_axi_w*/o_axi_wready write data channel (wstrb byte enables)
//   o_axi_bvalid/bready   write response (always OKAY)
//   i_axi_ar*/o_axi_ar*   read address channel
//   o_axi_r*/i_axi_rready read data channel, latency 1
//   o_irq                 registered match AND irq_en

module axi_lite_timer #(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter int          PRESCALE_WIDTH = 16,
    parameter logic [31:0] RESET_COMPARE  = 32'hFFFF_FFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_axi_awvalid,
    output logic                  o_axi_awready,
    input  logic [ADDR_WIDTH-1:0] i_axi_awaddr,
    input  logic                  i_axi_wvalid,
    output logic                  o_axi_wready,
    input  logic [DATA_WIDTH-1:0] i_axi_wdata,
    input  logic [3:0]            i_axi_wstrb,
    output logic                  o_axi_bvalid,
    input  logic                  i_axi_bready,
    input  logic                  i_axi_arvalid,
    output logic                  o_axi_arready,
    input  logic [ADDR_WIDTH-1:0] i_axi_araddr,
    output logic                  o_axi_rvalid,
    input  logic                  i_axi_rready,
    output logic [DATA_WIDTH-1:0] o_axi_rdata,
    output logic                  o_irq
);

    localparam logic [2:0] SEL_CTRL     = 3'd0;
    localparam logic [2:0] SEL_PRESCALE = 3'd1;
    localparam logic [2:0] SEL_COUNT    = 3'd2;
    localparam logic [2:0] SEL_COMPARE  = 3'd3;
    localparam logic [2:0] SEL_STATUS   = 3'd4;

    logic                      ctrl_enable;
    logic                      ctrl_irq_en;
    logic                      ctrl_auto_reload;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic [PRESCALE_WIDTH-1:0] pre_cnt;
    logic [31:0]               count;
    logic [31:0]               compare;
    logic                      match;

    logic                      wr_en;
    logic                      rd_en;
    logic [2:0]                wr_sel;
    logic [2:0]                rd_sel;
    logic                      tick;
    logic                      hit;
    logic                      status_clr;
    logic [31:0]               prescale_ext;
    logic [31:0]               prescale_merged;
    logic [31:0]               count_merged;
    logic [31:0]               compare_merged;
    logic [31:0]               rd_val;
    logic                      unused_bits;

    function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                               input logic [31:0] wd,
                                               input logic [3:0]  be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*8 +: 8] = be[i] ? wd[i*8 +: 8] : cur[i*8 +: 8];
        end
        return r;
    endfunction

    // Ready is combinational so the register write lands on the same edge as
    // the handshake; gating with reset keeps every output low during reset.
    assign wr_en  = i_axi_awvalid & i_axi_wvalid & ~o_axi_bvalid & ~reset;
    assign rd_en  = i_axi_arvalid & ~o_axi_rvalid & ~reset;
    assign o_axi_awready = wr_en;
    assign o_axi_wready  = wr_en;
    assign o_axi_arready = rd_en;

    assign wr_sel = i_axi_awaddr[4:2];
    assign rd_sel = i_axi_araddr[4:2];

    assign tick       = ctrl_enable && (pre_cnt == prescale);
    assign hit        = (count == compare);
    assign status_clr = wr_en && (wr_sel == SEL_STATUS) && i_axi_wstrb[0] && i_axi_wdata[0];

    always_comb begin
        prescale_ext = '0;
        prescale_ext[PRESCALE_WIDTH-1:0] = prescale;
    end

    assign prescale_merged = byte_merge(prescale_ext, i_axi_wdata, i_axi_wstrb);
    assign count_merged    = byte_merge(count, i_axi_wdata, i_axi_wstrb);
    assign compare_merged  = byte_merge(compare, i_axi_wdata, i_axi_wstrb);

    always_comb begin
        rd_val = '0;
        case (rd_sel)
            SEL_CTRL:     rd_val = {29'd0, ctrl_auto_reload, ctrl_irq_en, ctrl_enable};
            SEL_PRESCALE: rd_val = prescale_ext;
            SEL_COUNT:    rd_val = count;
            SEL_COMPARE:  rd_val = compare;
            SEL_STATUS:   rd_val = {31'd0, match};
            default:      rd_val = '0;
        endcase
    end

    assign unused_bits = ^{i_axi_awaddr[ADDR_WIDTH-1:5], i_axi_awaddr[1:0],
                           i_axi_araddr[ADDR_WIDTH-1:5], i_axi_araddr[1:0],
                           prescale_merged[31:PRESCALE_WIDTH]};

    always_ff @(posedge clk) begin
        if (reset) begin
            o_axi_bvalid     <= 1'b0;
            o_axi_rvalid     <= 1'b0;
            o_axi_rdata      <= '0;
            o_irq            <= 1'b0;
            ctrl_enable      <= 1'b0;
            ctrl_irq_en      <= 1'b0;
            ctrl_auto_reload <= 1'b0;
            prescale         <= '0;
            pre_cnt          <= '0;
            count            <= '0;
            compare          <= RESET_COMPARE;
            match            <= 1'b0;
        end else begin
            if (wr_en) begin
                o_axi_bvalid <= 1'b1;
            end else if (o_axi_bvalid && i_axi_bready) begin
                o_axi_bvalid <= 1'b0;
            end

            if (rd_en) begin
                o_axi_rvalid <= 1'b1;
                o_axi_rdata  <= rd_val;
            end else if (o_axi_rvalid && i_axi_rready) begin
                o_axi_rvalid <= 1'b0;
            end

            if (wr_en && (wr_sel == SEL_CTRL) && i_axi_wstrb[0]) begin
                ctrl_enable      <= i_axi_wdata[0];
                ctrl_irq_en      <= i_axi_wdata[1];
                ctrl_auto_reload <= i_axi_wdata[2];
            end

            // A PRESCALE write restarts the divider so the new period starts clean.
            if (wr_en && (wr_sel == SEL_PRESCALE)) begin
                prescale <= prescale_merged[PRESCALE_WIDTH-1:0];
                pre_cnt  <= '0;
            end else if (tick) begin
                pre_cnt <= '0;
            end else if (ctrl_enable) begin
                pre_cnt <= pre_cnt + PRESCALE_WIDTH'(1);
            end

            // Bus write beats the tick increment.
            if (wr_en && (wr_sel == SEL_COUNT)) begin
                count <= count_merged;
            end else if (tick) begin
                count <= (hit && ctrl_auto_reload) ? 32'd0 : count + 32'd1;
            end

            if (wr_en && (wr_sel == SEL_COMPARE)) begin
                compare <= compare_merged;
            end

            // Set beats clear when both land on the same edge.
            if (tick && hit) begin
                match <= 1'b1;
            end else if (status_clr) begin
                match <= 1'b0;
            end

            o_irq <= match & ctrl_irq_en;
        end
    end

endmodule

// File: tb/tb_axi_lite_timer.sv
module tb_axi_lite_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid, irq;
    logic [31:0] rdata;

    axi_lite_timer dut (
        .clk           (clk),
        .reset         (reset),
        .i_axi_awvalid (awvalid),
        .o_axi_awready (awready),
        .i_axi_awaddr  (awaddr),
        .i_axi_wvalid  (wvalid),
        .o_axi_wready  (wready),
        .i_axi_wdata   (wdata),
        .i_axi_wstrb   (wstrb),
        .o_axi_bvalid  (bvalid),
        .i_axi_bready  (bready),
        .i_axi_arvalid (arvalid),
        .o_axi_arready (arready),
        .i_axi_araddr  (araddr),
        .o_axi_rvalid  (rvalid),
        .i_axi_rready  (rready),
        .o_axi_rdata   (rdata),
        .o_irq         (irq)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [31:0] A_CTRL = 32'h00, A_PRE = 32'h04, A_CNT = 32'h08;
    localparam logic [31:0] A_CMP = 32'h0C, A_STAT = 32'h10;

    int tests = 0;
    int fails = 0;
    int unsigned wr_edge, rd_edge, pw;
    int k;
    logic [31:0] d;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input logic [31:0] exp);
        vec_t v;
        v.wr = wr; v.addr = addr; v.data = data; v.strb = strb; v.exp = exp;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Entered at a falling edge; handshake on the next rising edge, returns
    // at the falling edge after the response has been consumed.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        awvalid = 1'b1; wvalid = 1'b1; awaddr = addr; wdata = data; wstrb = strb; bready = 1'b1;
        #1;
        check("wr_ready", {30'd0, awready, wready}, 32'd3);
        @(negedge clk);
        wr_edge = cyc;
        awvalid = 1'b0; wvalid = 1'b0;
        check("wr_bvalid", 32'(bvalid), 32'd1);
        @(negedge clk);
        check("wr_bvalid_clr", 32'(bvalid), 32'd0);
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
        arvalid = 1'b1; araddr = addr; rready = 1'b1;
        #1;
        check("rd_arready", 32'(arready), 32'd1);
        @(negedge clk);
        rd_edge = cyc;
        arvalid = 1'b0;
        check("rd_rvalid", 32'(rvalid), 32'd1);
        data = rdata;
        @(negedge clk);
        check("rd_rvalid_clr", 32'(rvalid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        awvalid = 0; wvalid = 0; bready = 1; arvalid = 0; rready = 1;
        awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {25'd0, awready, wready, bvalid, arready, rvalid, irq, 1'b0}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Register-level vectors with the counter disabled.
        add(0, A_CTRL, 0, 0, 32'h0);
        add(0, A_PRE,  0, 0, 32'h0);
        add(0, A_CNT,  0, 0, 32'h0);
        add(0, A_CMP,  0, 0, 32'hFFFF_FFFF);
        add(0, A_STAT, 0, 0, 32'h0);
        add(0, 32'h14, 0, 0, 32'h0);
        add(1, A_CTRL, 32'hFFFF_FFFE, 4'hF, 0);
        add(0, A_CTRL, 0, 0, 32'h6);
        add(1, A_CTRL, 32'h0, 4'hF, 0);
        add(0, A_CTRL, 0, 0, 32'h0);
        add(1, A_PRE,  32'hABCD_1234, 4'hF, 0);
        add(0, A_PRE,  0, 0, 32'h1234);
        add(1, A_PRE,  32'h0000_FF00, 4'h2, 0);
        add(0, A_PRE,  0, 0, 32'hFF34);
        add(1, A_CMP,  32'h1234_5678, 4'hF, 0);
        add(1, A_CMP,  32'h00AB_0000, 4'h4, 0);
        add(0, A_CMP,  0, 0, 32'h12AB_5678);
        add(1, A_CMP,  32'hCD00_0000, 4'h8, 0);
        add(0, A_CMP,  0, 0, 32'hCDAB_5678);
        add(1, A_CNT,  32'h1234_5678, 4'hF, 0);
        add(1, A_CNT,  32'hFFFF_FFAA, 4'h1, 0);
        add(0, A_CNT,  0, 0, 32'h1234_56AA);
        add(1, 32'h14, 32'hFFFF_FFFF, 4'hF, 0);
        add(0, 32'h14, 0, 0, 32'h0);
        add(0, 32'h1C, 0, 0, 32'h0);
        add(1, A_STAT, 32'h1, 4'h1, 0);
        add(0, A_STAT, 0, 0, 32'h0);

        // Read stall: rdata must hold while rready is low.
        arvalid = 1'b1; araddr = A_CMP; rready = 1'b0;
        #1;
        check("stall_arready", 32'(arready), 32'd1);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("stall_rvalid", 32'(rvalid), 32'd1);
            check("stall_rdata", rdata, 32'hFFFF_FFFF);
            check("stall_no_reaccept", 32'(arready), 32'd0);
            @(negedge clk);
        end
        arvalid = 1'b0; rready = 1'b1;
        @(negedge clk);
        check("stall_rvalid_clr", 32'(rvalid), 32'd0);

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            end else begin
                axi_read(vecs[i].addr, d);
                check($sformatf("vec%0d_rdata", i), d, vecs[i].exp);
            end
        end

        // AW without W, then W, then a held response blocking a second write.
        awvalid = 1'b1; wvalid = 1'b0; awaddr = A_CMP; wdata = 32'h1111_1111; wstrb = 4'hF; bready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("aw_only_no_ready", {30'd0, awready, wready}, 32'd0);
            @(negedge clk);
        end
        wvalid = 1'b1;
        #1;
        check("aw_w_ready", {30'd0, awready, wready}, 32'd3);
        @(negedge clk);
        wdata = 32'h2222_2222;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bhold_bvalid", 32'(bvalid), 32'd1);
            check("bhold_no_accept", {30'd0, awready, wready}, 32'd0);
            @(negedge clk);
        end
        axi_read(A_CMP, d);
        check("bhold_first_data", d, 32'h1111_1111);
        check("bhold_bvalid_after_rd", 32'(bvalid), 32'd1);
        bready = 1'b1;
        @(negedge clk);
        #1;
        check("second_wr_ready", {30'd0, awready, wready}, 32'd3);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("second_wr_bvalid", 32'(bvalid), 32'd1);
        @(negedge clk);
        axi_read(A_CMP, d);
        check("second_wr_data", d, 32'h2222_2222);

        // Prescaled counting: PRESCALE=3 gives one tick every 4 cycles.
        axi_write(A_CNT, 32'd0, 4'hF);
        axi_write(A_PRE, 32'd3, 4'hF);
        axi_write(A_CMP, 32'd5, 4'hF);
        axi_write(A_STAT, 32'd1, 4'h1);
        axi_write(A_CTRL, 32'h3, 4'hF);
        pw = wr_edge;
        for (int i = 0; i < 8; i++) begin
            axi_read(A_CNT, d);
            k = int'(rd_edge - 1 - pw);
            check($sformatf("ps_count_k%0d", k), d, 32'(k / 4));
            axi_read(A_STAT, d);
            k = int'(rd_edge - 1 - pw);
            check($sformatf("ps_match_k%0d", k), d, (k >= 24) ? 32'd1 : 32'd0);
            check($sformatf("ps_irq_e%0d", cyc - pw), 32'(irq), (cyc - pw >= 25) ? 32'd1 : 32'd0);
        end

        // Auto-reload with PRESCALE=0: COUNT cycles 0,1,2.
        axi_write(A_CTRL, 32'h0, 4'hF);
        axi_write(A_CNT, 32'd0, 4'hF);
        axi_write(A_PRE, 32'd0, 4'hF);
        axi_write(A_CMP, 32'd2, 4'hF);
        axi_write(A_STAT, 32'd1, 4'h1);
        axi_write(A_CTRL, 32'h5, 4'hF);
        pw = wr_edge;
        for (int i = 0; i < 6; i++) begin
            axi_read(A_CNT, d);
            k = int'(rd_edge - 1 - pw);
            check($sformatf("ar_count_k%0d", k), d, 32'(k % 3));
            check("ar_irq_low", 32'(irq), 32'd0);
        end
        axi_read(A_STAT, d);
        check("ar_match_set", d, 32'd1);
        // Clear on an edge with no match: flag reads back 0.
        while (((cyc + 1 - pw) % 3) != 1) @(negedge clk);
        axi_write(A_STAT, 32'd1, 4'h1);
        axi_read(A_STAT, d);
        check("ar_clear_no_collide", d, 32'd0);
        // Clear on the same edge as a match: set wins.
        while (((cyc + 1 - pw) % 3) != 0) @(negedge clk);
        axi_write(A_STAT, 32'd1, 4'h1);
        axi_read(A_STAT, d);
        check("ar_clear_collide", d, 32'd1);
        check("ar_irq_final", 32'(irq), 32'd0);
        axi_write(A_CTRL, 32'h4, 4'hF);
        axi_write(A_STAT, 32'd1, 4'h1);
        axi_read(A_STAT, d);
        check("ar_clear_stopped", d, 32'd0);

        // Wrap from 0xFFFF_FFFF to 0 without a match.
        axi_write(A_CTRL, 32'h0, 4'hF);
        axi_write(A_CMP, 32'h10, 4'hF);
        axi_write(A_CNT, 32'hFFFF_FFFF, 4'hF);
        axi_write(A_CTRL, 32'h1, 4'hF);
        axi_read(A_CNT, d);
        check("wrap_count", d, 32'd0);
        axi_read(A_STAT, d);
        check("wrap_no_match", d, 32'd0);
        axi_write(A_CTRL, 32'h0, 4'hF);

        // Reset in the middle of pending read and write responses.
        axi_write(A_CMP, 32'd0, 4'hF);
        axi_write(A_CNT, 32'd0, 4'hF);
        axi_write(A_CTRL, 32'h3, 4'hF);
        @(negedge clk);
        check("pre_rst_irq", 32'(irq), 32'd1);
        awvalid = 1'b1; wvalid = 1'b1; awaddr = A_CTRL; wdata = 32'h7; wstrb = 4'hF; bready = 1'b0;
        arvalid = 1'b1; araddr = A_CNT; rready = 1'b0;
        #1;
        check("pre_rst_ready", {29'd0, awready, wready, arready}, 32'd7);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("pre_rst_valids", {30'd0, bvalid, rvalid}, 32'd3);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_valids", {29'd0, bvalid, rvalid, irq}, 32'd0);
        check("rst_mid_rdata", rdata, 32'd0);
        reset = 1'b0; bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        axi_read(A_CNT, d);
        check("post_rst_count", d, 32'd0);
        axi_read(A_CTRL, d);
        check("post_rst_ctrl", d, 32'd0);
        axi_read(A_CMP, d);
        check("post_rst_compare", d, 32'hFFFF_FFFF);
        axi_read(A_STAT, d);
        check("post_rst_status", d, 32'd0);
        check("post_rst_irq", 32'(irq), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
